// File: rtl/phase_sched_pkg.sv
// Shared types and constants for the phase_processor round-robin scheduler.
package phase_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int FACT_W = 4;
  localparam int N_FACT = 3;
  localparam int MULT_W = FACT_W * N_FACT;

  // Channel-id width; a single channel still needs one bit to carry an id.
  function automatic int ch_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  // Rotate so bit 0 of w_rot is the channel just after the last grant.
  assign w_dbl = {req, req} >> (int'(last) + 1);
  assign w_rot = w_dbl[N-1:0];
  assign any   = |req;

  // Scan from the far end down so the nearest request wins.
  always_comb begin
    grant_idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        grant_idx = IDX_W'((int'(last) + 1 + j) % N);
      end else begin
        grant_idx = grant_idx;
      end
    end
  end

endmodule

// File: rtl/phase_sched.sv
// Shares one phase_processor among N_CH channels: one-deep sample slot per
// channel, round-robin issue, completion wait with timeout abort.
module phase_sched
  import phase_sched_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int MAG_W   = 21,
  parameter int PHASE_W = 22,
  parameter int TIMEOUT = 2047
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [N_CH-1:0]              ch_strobe,
  input  logic [N_CH*MAG_W-1:0]        ch_mag,
  input  logic [N_CH*PHASE_W-1:0]      ch_phase,
  input  logic [N_CH*MULT_W-1:0]       ch_mult,
  input  logic                         clr_drop,
  output logic [MAG_W-1:0]             pp_mag,
  output logic [PHASE_W-1:0]           pp_phase,
  output logic [FACT_W-1:0]            pp_mult_factors,
  output logic [FACT_W-1:0]            pp_mult_factors_1,
  output logic [FACT_W-1:0]            pp_mult_factors_2,
  output logic                         pp_strobe,
  input  logic                         pp_strobe_out,
  output logic                         res_valid,
  output logic [ch_id_w(N_CH)-1:0]     res_ch,
  output logic                         timeout_err,
  output logic [N_CH-1:0]              drop_flags,
  output logic                         busy
);

  localparam int CH_W  = ch_id_w(N_CH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [MAG_W-1:0]   w_mag        [N_CH];
  logic [PHASE_W-1:0] w_phase      [N_CH];
  logic [MULT_W-1:0]  w_mult       [N_CH];
  logic [MAG_W-1:0]   r_slot_mag   [N_CH];
  logic [PHASE_W-1:0] r_slot_phase [N_CH];

  logic [N_CH-1:0]    r_pending, w_pending_nxt, w_drop_set, r_drop;
  logic [CH_W-1:0]    r_last, w_sel, r_res_ch;
  logic               w_any, w_select;
  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt_inc;
  logic [MAG_W-1:0]   r_pp_mag;
  logic [PHASE_W-1:0] r_pp_phase;
  logic [FACT_W-1:0]  r_pp_f0, r_pp_f1, r_pp_f2;
  logic               r_pp_strobe, r_res_valid, r_timeout_err, r_busy;

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign w_mag[g]   = ch_mag[g*MAG_W +: MAG_W];
    assign w_phase[g] = ch_phase[g*PHASE_W +: PHASE_W];
    assign w_mult[g]  = ch_mult[g*MULT_W +: MULT_W];
  end

  rr_pick #(.N(N_CH), .IDX_W(CH_W)) u_pick (
    .req       (r_pending),
    .last      (r_last),
    .grant_idx (w_sel),
    .any       (w_any)
  );

  // The cycle after a job ends is left free so the result is not disturbed by a new strobe.
  assign w_select  = (r_state == IDLE) && w_any && !r_res_valid && !r_timeout_err;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // A strobe into the slot being selected refills it without counting as a drop.
  always_comb begin
    w_pending_nxt = r_pending;
    w_drop_set    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_select && (w_sel == CH_W'(i))) begin
        w_pending_nxt[i] = ch_strobe[i];
      end else if (ch_strobe[i]) begin
        w_pending_nxt[i] = 1'b1;
        w_drop_set[i]    = r_pending[i];
      end else begin
        w_pending_nxt[i] = r_pending[i];
      end
    end
  end

  // Per-channel sample slots, pending bits and sticky drop flags.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pending <= '0;
      r_drop    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_slot_mag[i]   <= '0;
        r_slot_phase[i] <= '0;
      end
    end else begin
      r_pending <= w_pending_nxt;
      r_drop    <= (clr_drop ? {N_CH{1'b0}} : r_drop) | w_drop_set;
      for (int i = 0; i < N_CH; i++) begin
        if (ch_strobe[i]) begin
          r_slot_mag[i]   <= w_mag[i];
          r_slot_phase[i] <= w_phase[i];
        end
      end
    end
  end

  // Issue/wait FSM with registered processor-side and status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= IDLE;
      r_last        <= CH_W'(N_CH - 1);
      r_cnt         <= '0;
      r_pp_mag      <= '0;
      r_pp_phase    <= '0;
      r_pp_f0       <= '0;
      r_pp_f1       <= '0;
      r_pp_f2       <= '0;
      r_pp_strobe   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_ch      <= '0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_pp_strobe   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_select) begin
            r_pp_mag    <= r_slot_mag[w_sel];
            r_pp_phase  <= r_slot_phase[w_sel];
            r_pp_f0     <= w_mult[w_sel][FACT_W-1:0];
            r_pp_f1     <= w_mult[w_sel][2*FACT_W-1:FACT_W];
            r_pp_f2     <= w_mult[w_sel][3*FACT_W-1:2*FACT_W];
            r_res_ch    <= w_sel;
            r_last      <= w_sel;
            r_pp_strobe <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (pp_strobe_out) begin
            r_res_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pp_mag            = r_pp_mag;
  assign pp_phase          = r_pp_phase;
  assign pp_mult_factors   = r_pp_f0;
  assign pp_mult_factors_1 = r_pp_f1;
  assign pp_mult_factors_2 = r_pp_f2;
  assign pp_strobe         = r_pp_strobe;
  assign res_valid         = r_res_valid;
  assign res_ch            = r_res_ch;
  assign timeout_err       = r_timeout_err;
  assign drop_flags        = r_drop;
  assign busy              = r_busy;

endmodule

// File: tb/tb_phase_sched.sv
// Directed bench for phase_sched: vector table for single jobs plus
// hand-written sequences for ordering, overwrite, timeout and reset.
module tb_phase_sched;

  localparam int N_CH    = 4;
  localparam int MAG_W   = 21;
  localparam int PHASE_W = 22;
  localparam int TO      = 24;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst;
  logic [N_CH-1:0]         ch_strobe;
  logic [N_CH*MAG_W-1:0]   ch_mag;
  logic [N_CH*PHASE_W-1:0] ch_phase;
  logic [N_CH*12-1:0]      ch_mult;
  logic                    clr_drop;
  logic [MAG_W-1:0]        pp_mag;
  logic [PHASE_W-1:0]      pp_phase;
  logic [3:0]              pp_mult_factors, pp_mult_factors_1, pp_mult_factors_2;
  logic                    pp_strobe, pp_strobe_out, res_valid, timeout_err, busy;
  logic [1:0]              res_ch;
  logic [N_CH-1:0]         drop_flags;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int               ch;
    logic [MAG_W-1:0] mag;
    logic [PHASE_W-1:0] phase;
    logic [3:0]       f0, f1, f2;
    int               lat;
  } vec_t;
  vec_t vecs [4];

  always #5 sys_clk = ~sys_clk;

  phase_sched #(.N_CH(N_CH), .MAG_W(MAG_W), .PHASE_W(PHASE_W), .TIMEOUT(TO)) dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .ch_strobe         (ch_strobe),
    .ch_mag            (ch_mag),
    .ch_phase          (ch_phase),
    .ch_mult           (ch_mult),
    .clr_drop          (clr_drop),
    .pp_mag            (pp_mag),
    .pp_phase          (pp_phase),
    .pp_mult_factors   (pp_mult_factors),
    .pp_mult_factors_1 (pp_mult_factors_1),
    .pp_mult_factors_2 (pp_mult_factors_2),
    .pp_strobe         (pp_strobe),
    .pp_strobe_out     (pp_strobe_out),
    .res_valid         (res_valid),
    .res_ch            (res_ch),
    .timeout_err       (timeout_err),
    .drop_flags        (drop_flags),
    .busy              (busy)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_sample(input int ch, input logic [MAG_W-1:0] m, input logic [PHASE_W-1:0] p);
    ch_mag[ch*MAG_W +: MAG_W]       = m;
    ch_phase[ch*PHASE_W +: PHASE_W] = p;
  endtask

  // From the issue cycle (or later), complete after lat cycles; ends in the res_valid cycle.
  task automatic finish_job(input int lat, input int ch);
    repeat (lat) tick();
    pp_strobe_out = 1'b1;
    tick();
    pp_strobe_out = 1'b0;
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_ch", 32'(res_ch), 32'(ch));
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  // From the res_valid cycle: one free cycle, then the next issue.
  task automatic next_issue(input int ch, input logic [MAG_W-1:0] m);
    tick();
    chk("gap_no_strobe", 32'(pp_strobe), 32'd0);
    tick();
    chk("next_strobe", 32'(pp_strobe), 32'd1);
    chk("next_ch", 32'(res_ch), 32'(ch));
    chk("next_mag", 32'(pp_mag), 32'(m));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_pp_mag", 32'(pp_mag), 32'd0);
    chk("rst_pp_phase", 32'(pp_phase), 32'd0);
    chk("rst_factors", 32'({pp_mult_factors_2, pp_mult_factors_1, pp_mult_factors}), 32'd0);
    chk("rst_pp_strobe", 32'(pp_strobe), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_ch", 32'(res_ch), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_drop", 32'(drop_flags), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int seen;
    vecs[0] = '{1, 21'd1,       22'd2,       4'd3, 4'd4, 4'd5, 20};
    vecs[1] = '{0, 21'h1FFFFF,  22'h3FFFFF,  4'd1, 4'd2, 4'd3, 4};
    vecs[2] = '{2, 21'h100000,  22'h200000,  4'd5, 4'd6, 4'd7, TO - 1};
    vecs[3] = '{3, 21'h0A5A5,   22'h15A5A5,  4'h8, 4'h9, 4'hA, 1};

    ch_strobe = '0; ch_mag = '0; ch_phase = '0; clr_drop = 1'b0; pp_strobe_out = 1'b0;
    ch_mult = {12'hA98, 12'h765, 12'h543, 12'h321};
    sys_rst = 1'b1;
    tick(); tick();
    sys_rst = 1'b0;
    chk_reset_outputs();
    for (int i = 0; i < N_CH; i++) set_sample(i, MAG_W'(32'h700 + i), PHASE_W'(32'h900 + i));

    // Table of single jobs; the last one leaves last=3.
    for (int v = 0; v < 4; v++) begin
      set_sample(vecs[v].ch, vecs[v].mag, vecs[v].phase);
      ch_strobe = 4'(1 << vecs[v].ch);
      tick();
      ch_strobe = '0;
      chk("v_no_strobe_t1", 32'(pp_strobe), 32'd0);
      tick();
      chk("v_strobe_t2", 32'(pp_strobe), 32'd1);
      chk("v_mag", 32'(pp_mag), 32'(vecs[v].mag));
      chk("v_phase", 32'(pp_phase), 32'(vecs[v].phase));
      chk("v_f0", 32'(pp_mult_factors), 32'(vecs[v].f0));
      chk("v_f1", 32'(pp_mult_factors_1), 32'(vecs[v].f1));
      chk("v_f2", 32'(pp_mult_factors_2), 32'(vecs[v].f2));
      chk("v_busy", 32'(busy), 32'd1);
      tick();
      chk("v_strobe_one_cycle", 32'(pp_strobe), 32'd0);
      finish_job(vecs[v].lat - 1, vecs[v].ch);
      chk("v_mag_held", 32'(pp_mag), 32'(vecs[v].mag));
      tick();
      chk("v_res_valid_pulse", 32'(res_valid), 32'd0);
    end

    // All four at once: order 0,1,2,3, each issue three cycles after completion.
    for (int i = 0; i < N_CH; i++) set_sample(i, MAG_W'(16 + i), PHASE_W'(32 + i));
    ch_strobe = 4'hF;
    tick();
    ch_strobe = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("all_strobe", 32'(pp_strobe), 32'd1);
      chk("all_ch", 32'(res_ch), 32'(k));
      chk("all_mag", 32'(pp_mag), 32'(16 + k));
      finish_job(3 + k, k);
      if (k < 3) begin
        tick();
        chk("all_gap", 32'(pp_strobe), 32'd0);
        tick();
      end
    end
    chk("all_no_drop", 32'(drop_flags), 32'd0);

    // Fairness: ch0 re-strobes during its own job, ch2 still goes next.
    tick();
    set_sample(0, 21'h40, 22'h40);
    set_sample(2, 21'h42, 22'h42);
    ch_strobe = 4'b0101;
    tick();
    ch_strobe = '0;
    tick();
    chk("fair_first_ch", 32'(res_ch), 32'd0);
    chk("fair_first_mag", 32'(pp_mag), 32'h40);
    set_sample(0, 21'h50, 22'h50);
    ch_strobe = 4'b0001;
    tick();
    ch_strobe = '0;
    finish_job(5, 0);
    next_issue(2, 21'h42);
    finish_job(2, 2);
    next_issue(0, 21'h50);
    finish_job(2, 0);

    // Overwrite while busy: newest sample issued, drop flagged, clr_drop clears.
    tick();
    set_sample(0, 21'h60, 22'h60);
    ch_strobe = 4'b0001;
    tick();
    ch_strobe = '0;
    tick();
    chk("ovw_first_ch", 32'(res_ch), 32'd0);
    set_sample(3, 21'd7, 22'd7);
    ch_strobe = 4'b1000;
    tick();
    set_sample(3, 21'd9, 22'd9);
    tick();
    ch_strobe = '0;
    chk("ovw_drop3", 32'(drop_flags), 32'b1000);
    finish_job(3, 0);
    next_issue(3, 21'd9);
    set_sample(1, 21'h11, 22'h11);
    ch_strobe = 4'b0010;
    tick();
    set_sample(1, 21'h12, 22'h12);
    clr_drop = 1'b1;
    tick();
    ch_strobe = '0;
    clr_drop = 1'b0;
    chk("drop_beats_clr", 32'(drop_flags), 32'b0010);
    clr_drop = 1'b1;
    tick();
    clr_drop = 1'b0;
    chk("clr_drop", 32'(drop_flags), 32'd0);
    finish_job(2, 3);
    next_issue(1, 21'h12);
    finish_job(2, 1);

    // Strobe into the slot in its select cycle: old issued, new kept, no drop.
    tick();
    set_sample(2, 21'h21, 22'h21);
    ch_strobe = 4'b0100;
    tick();
    set_sample(2, 21'h22, 22'h22);
    tick();
    ch_strobe = '0;
    chk("sel_strobe_ch", 32'(res_ch), 32'd2);
    chk("sel_strobe_old", 32'(pp_mag), 32'h21);
    chk("sel_strobe_nodrop", 32'(drop_flags), 32'd0);
    finish_job(2, 2);
    next_issue(2, 21'h22);
    finish_job(2, 2);

    // Timeout: pulse at issue + TO + 1, then the waiting channel goes.
    tick();
    set_sample(3, 21'h33, 22'h33);
    ch_strobe = 4'b1000;
    tick();
    ch_strobe = '0;
    tick();
    chk("to_issue_ch", 32'(res_ch), 32'd3);
    set_sample(0, 21'h30, 22'h30);
    ch_strobe = 4'b0001;
    tick();
    ch_strobe = '0;
    repeat (TO - 1) tick();
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    chk("to_busy", 32'(busy), 32'd1);
    tick();
    chk("to_pulse", 32'(timeout_err), 32'd1);
    chk("to_no_result", 32'(res_valid), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_ch_held", 32'(res_ch), 32'd3);
    next_issue(0, 21'h30);
    finish_job(2, 0);

    // Completion pulse outside WAIT is ignored.
    tick();
    pp_strobe_out = 1'b1;
    tick();
    pp_strobe_out = 1'b0;
    chk("stray_done", 32'(res_valid), 32'd0);

    // Reset mid-job drops everything, including last.
    set_sample(1, 21'h41, 22'h41);
    set_sample(2, 21'h42, 22'h42);
    ch_strobe = 4'b0110;
    tick();
    ch_strobe = '0;
    tick();
    chk("rst_job_ch", 32'(res_ch), 32'd1);
    tick();
    ch_strobe = 4'b0100;
    tick();
    ch_strobe = '0;
    chk("rst_pre_drop", 32'(drop_flags), 32'b0100);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk_reset_outputs();
    pp_strobe_out = 1'b1;
    tick();
    pp_strobe_out = 1'b0;
    chk("late_done", 32'(res_valid), 32'd0);
    seen = 0;
    repeat (6) begin
      tick();
      if (pp_strobe) seen++;
    end
    chk("no_pending_after_rst", 32'(seen), 32'd0);
    set_sample(0, 21'h5, 22'h5);
    set_sample(3, 21'h6, 22'h6);
    ch_strobe = 4'b1001;
    tick();
    ch_strobe = '0;
    tick();
    chk("post_rst_prio", 32'(res_ch), 32'd0);
    chk("post_rst_mag", 32'(pp_mag), 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
